// File: rtl/id_register_file_pkg.sv
// Shared sizing constants and small helpers for the decode-stage register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
//
// Contents:
//   DATA_WIDTH / ADDR_WIDTH / SB_CNT_W : default widths used by the top and sub-module.
//   NUM_REGS                           : register count derived from ADDR_WIDTH.
//   REG_ZERO                           : index of the hard-wired zero register.
//   sat_inc / floor_dec                : saturating counter step helpers.
package id_register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int SB_CNT_W   = 2;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int REG_ZERO   = 0;

    // Count up, sticking at all-ones instead of wrapping.
    function automatic logic [SB_CNT_W-1:0] sat_inc(input logic [SB_CNT_W-1:0] v);
        sat_inc = (v == {SB_CNT_W{1'b1}}) ? v : v + SB_CNT_W'(1);
    endfunction

    // Count down, sticking at zero instead of wrapping.
    function automatic logic [SB_CNT_W-1:0] floor_dec(input logic [SB_CNT_W-1:0] v);
        floor_dec = (v == '0) ? v : v - SB_CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_register_file_load_scoreboard.sv
// Per-register in-flight load counters and load-use stall generation for ID.
// Latency: counters update on the next rising edge; stall_id_o is combinational.
// Backpressure: stall_id_o holds IF/ID; a load issued while stalled is not counted.
//
// Ports:
//   clk_i, rst_ni             : clock, async active-low reset (clears all counters)
//   issue_load_i, issue_reg_i : load leaving ID and its destination register
//   commit_load_i, commit_reg_i : load result committing in WB and its destination
//   flush_i                   : clear every counter on the next edge
//   read_reg1_i, read_reg2_i  : ID source registers checked for hazards
//   stall_id_o                : load-use hazard present this cycle
module id_register_file_load_scoreboard
    import id_register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = id_register_file_pkg::ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  issue_load_i,
    input  logic [ADDR_WIDTH-1:0] issue_reg_i,
    input  logic                  commit_load_i,
    input  logic [ADDR_WIDTH-1:0] commit_reg_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] read_reg1_i,
    input  logic [ADDR_WIDTH-1:0] read_reg2_i,
    output logic                  stall_id_o
);

    localparam int                    NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] R0    = ADDR_WIDTH'(REG_ZERO);

    logic [SB_CNT_W-1:0] cnt_q [NREGS];
    logic [SB_CNT_W-1:0] cnt_d [NREGS];

    logic stall1;
    logic stall2;
    logic inc_vld;
    logic dec_vld;

    // A load is only counted when it actually leaves ID, i.e. not while stalled.
    // stall_id_o depends only on cnt_q and the read/commit ports, so there is no
    // combinational loop through inc_vld.
    assign inc_vld = issue_load_i && !stall_id_o && (issue_reg_i != R0);
    assign dec_vld = commit_load_i && (commit_reg_i != R0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else begin
                // Simultaneous inc and dec on the same register cancel out.
                if (inc_vld && (issue_reg_i == ADDR_WIDTH'(r)) &&
                    !(dec_vld && (commit_reg_i == ADDR_WIDTH'(r)))) begin
                    cnt_d[r] = sat_inc(cnt_q[r]);
                end else if (dec_vld && (commit_reg_i == ADDR_WIDTH'(r)) &&
                             !(inc_vld && (issue_reg_i == ADDR_WIDTH'(r)))) begin
                    cnt_d[r] = floor_dec(cnt_q[r]);
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // A source with exactly one load outstanding whose result commits this
    // cycle is served by the write bypass, so it does not stall.
    always_comb begin
        stall1 = 1'b0;
        if (read_reg1_i != R0 && cnt_q[read_reg1_i] != '0) begin
            stall1 = !((cnt_q[read_reg1_i] == SB_CNT_W'(1)) &&
                       commit_load_i && (commit_reg_i == read_reg1_i));
        end
    end

    always_comb begin
        stall2 = 1'b0;
        if (read_reg2_i != R0 && cnt_q[read_reg2_i] != '0) begin
            stall2 = !((cnt_q[read_reg2_i] == SB_CNT_W'(1)) &&
                       commit_load_i && (commit_reg_i == read_reg2_i));
        end
    end

    assign stall_id_o = stall1 || stall2;

endmodule

// File: rtl/id_register_file.sv
// Decode-stage register file: WB write port, two bypassed combinational read ports, load-use stall.
// Latency: reads are zero-latency (same-cycle WB write forwarded); writes visible after the edge.
// Backpressure: stall_id_o asks IF/ID to hold while a source register awaits an in-flight load.
//
// Ports:
//   clk_i, rst_ni               : clock, async active-low reset (clears array and scoreboard)
//   reg_write_i, wb_load_i      : WB commit enable; commit is a load result
//   write_reg_i, write_data_i   : WB destination and data
//   read_reg1_i/read_data1_o    : rs read port
//   read_reg2_i/read_data2_o    : rt read port
//   issue_load_i, issue_reg_i   : load leaving ID and its destination
//   flush_i                     : squash; clears all scoreboard counters
//   stall_id_o                  : hold IF/ID, bubble into EX
module id_register_file
    import id_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = id_register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = id_register_file_pkg::ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  reg_write_i,
    input  logic                  wb_load_i,
    input  logic [ADDR_WIDTH-1:0] write_reg_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_reg1_i,
    input  logic [ADDR_WIDTH-1:0] read_reg2_i,
    output logic [DATA_WIDTH-1:0] read_data1_o,
    output logic [DATA_WIDTH-1:0] read_data2_o,
    input  logic                  issue_load_i,
    input  logic [ADDR_WIDTH-1:0] issue_reg_i,
    input  logic                  flush_i,
    output logic                  stall_id_o
);

    localparam int                    NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] R0    = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];

    logic wr_en;

    // r0 is never written, so it stays at its reset value of zero.
    assign wr_en = reg_write_i && (write_reg_i != R0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr_en) begin
            regs_d[write_reg_i] = write_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read ports: forced to zero while in reset so a write presented during
    // reset cannot leak through the bypass.
    always_comb begin
        read_data1_o = '0;
        if (rst_ni && read_reg1_i != R0) begin
            read_data1_o = (wr_en && write_reg_i == read_reg1_i) ? write_data_i
                                                                 : regs_q[read_reg1_i];
        end
    end

    always_comb begin
        read_data2_o = '0;
        if (rst_ni && read_reg2_i != R0) begin
            read_data2_o = (wr_en && write_reg_i == read_reg2_i) ? write_data_i
                                                                 : regs_q[read_reg2_i];
        end
    end

    id_register_file_load_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_load_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_load_i  (issue_load_i),
        .issue_reg_i   (issue_reg_i),
        .commit_load_i (reg_write_i && wb_load_i),
        .commit_reg_i  (write_reg_i),
        .flush_i       (flush_i),
        .read_reg1_i   (read_reg1_i),
        .read_reg2_i   (read_reg2_i),
        .stall_id_o    (stall_id_o)
    );

endmodule

// File: tb/tb_id_register_file.sv
// Directed bench for id_register_file: expected values queued at drive time, popped at check time.
module tb_id_register_file;

    logic        clk;
    logic        rst_n;
    logic        reg_write;
    logic        wb_load;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        issue_load;
    logic [4:0]  issue_reg;
    logic        flush;
    logic        stall_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];

    id_register_file dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .reg_write_i  (reg_write),
        .wb_load_i    (wb_load),
        .write_reg_i  (write_reg),
        .write_data_i (write_data),
        .read_reg1_i  (read_reg1),
        .read_reg2_i  (read_reg2),
        .read_data1_o (read_data1),
        .read_data2_o (read_data2),
        .issue_load_i (issue_load),
        .issue_reg_i  (issue_reg),
        .flush_i      (flush),
        .stall_id_o   (stall_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        wb_load    = 1'b0;
        write_reg  = '0;
        write_data = '0;
        issue_load = 1'b0;
        issue_reg  = '0;
        flush      = 1'b0;
    endtask

    initial begin
        idle();
        read_reg1 = '0;
        read_reg2 = '0;
        rst_n     = 1'b0;

        // 1: reset state, all registers read zero, no stall
        @(negedge clk);
        for (int r = 1; r < 32; r++) begin
            read_reg1 = 5'(r);
            read_reg2 = 5'(32 - r);
            #1;
            expect_val(32'h0); check("rst_rd1", read_data1);
            expect_val(32'h0); check("rst_rd2", read_data2);
            expect_val(32'h0); check("rst_stall", {31'h0, stall_id});
        end
        // write presented during reset is neither bypassed nor stored
        reg_write = 1'b1; write_reg = 5'd3; write_data = 32'h5555_AAAA; read_reg1 = 5'd3;
        #1;
        expect_val(32'h0); check("rst_bypass", read_data1);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        expect_val(32'h0); check("rst_nowrite", read_data1);

        // 2: write r5 with same-cycle bypass, then stored value
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        read_reg1 = 5'd5; read_reg2 = 5'd6;
        #1;
        expect_val(32'hDEAD_BEEF); check("wr5_bypass", read_data1);
        expect_val(32'h0);         check("wr5_other",  read_data2);
        @(negedge clk);
        idle();
        read_reg2 = 5'd5;
        #1;
        expect_val(32'hDEAD_BEEF); check("wr5_stored1", read_data1);
        expect_val(32'hDEAD_BEEF); check("wr5_stored2", read_data2);

        // 3: writes to r0 are dropped
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h0000_1234;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1;
        expect_val(32'h0); check("r0_wrcyc", read_data1);
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h0); check("r0_after", read_data2);

        // 4: load-use on r8; a load issued while stalled is ignored
        @(negedge clk);
        issue_load = 1'b1; issue_reg = 5'd8;
        #1;
        expect_val(32'h0); check("ld8_issue_nostall", {31'h0, stall_id});
        @(negedge clk);
        issue_load = 1'b1; issue_reg = 5'd12; read_reg2 = 5'd8;
        #1;
        expect_val(32'h1); check("ld8_stall_a", {31'h0, stall_id});
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h1); check("ld8_stall_b", {31'h0, stall_id});
        @(negedge clk);
        reg_write = 1'b1; wb_load = 1'b1; write_reg = 5'd8; write_data = 32'hCAFE_0008;
        #1;
        expect_val(32'h0);         check("ld8_commit_stall", {31'h0, stall_id});
        expect_val(32'hCAFE_0008); check("ld8_commit_data",  read_data2);
        @(negedge clk);
        idle();
        read_reg1 = 5'd12;
        #1;
        expect_val(32'h0);         check("ld8_after_stall", {31'h0, stall_id});
        expect_val(32'hCAFE_0008); check("ld8_after_data",  read_data2);

        // 5: two loads in flight on r9
        @(negedge clk);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        issue_load = 1'b1; issue_reg = 5'd9;
        @(negedge clk);
        issue_load = 1'b1; issue_reg = 5'd9;
        @(negedge clk);
        idle();
        read_reg1 = 5'd9;
        #1;
        expect_val(32'h1); check("ld9_two_stall", {31'h0, stall_id});
        @(negedge clk);
        reg_write = 1'b1; wb_load = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0901;
        #1;
        expect_val(32'h1); check("ld9_commit1_stall", {31'h0, stall_id});
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h1); check("ld9_between_stall", {31'h0, stall_id});
        @(negedge clk);
        reg_write = 1'b1; wb_load = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0902;
        #1;
        expect_val(32'h0);         check("ld9_commit2_stall", {31'h0, stall_id});
        expect_val(32'h0000_0902); check("ld9_commit2_data",  read_data1);
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h0); check("ld9_after_stall", {31'h0, stall_id});

        // saturation: four loads to r11 hold the counter at 3, not 0
        read_reg1 = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue_load = 1'b1; issue_reg = 5'd11;
        end
        @(negedge clk);
        idle();
        // a non-load write does not retire a scoreboard entry
        reg_write = 1'b1; write_reg = 5'd11; write_data = 32'h0000_0B00; read_reg2 = 5'd11;
        #1;
        expect_val(32'h1);         check("sat_stall", {31'h0, stall_id});
        expect_val(32'h0000_0B00); check("sat_alu_bypass", read_data2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            reg_write = 1'b1; wb_load = 1'b1; write_reg = 5'd11; write_data = 32'h0000_0B00 + 32'(i);
            #1;
            expect_val((i == 3) ? 32'h0 : 32'h1); check("sat_drain_stall", {31'h0, stall_id});
        end
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h0000_0B03); check("sat_final_data", read_data2);

        // 6: flush clears a pending load on r10
        read_reg2 = 5'd0;
        @(negedge clk);
        issue_load = 1'b1; issue_reg = 5'd10;
        @(negedge clk);
        idle();
        read_reg1 = 5'd10;
        #1;
        expect_val(32'h1); check("fl_pending", {31'h0, stall_id});
        @(negedge clk);
        flush = 1'b1;
        #1;
        expect_val(32'h1); check("fl_same_cycle", {31'h0, stall_id});
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h0); check("fl_cleared", {31'h0, stall_id});

        // reset pulsed mid-stall clears stall and array at once
        @(negedge clk);
        issue_load = 1'b1; issue_reg = 5'd10;
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h0000_1010;
        @(negedge clk);
        idle();
        #1;
        expect_val(32'h1);         check("rst_mid_stall", {31'h0, stall_id});
        expect_val(32'h0000_1010); check("rst_mid_data",  read_data1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val(32'h0); check("rst_mid_stall_clr", {31'h0, stall_id});
        expect_val(32'h0); check("rst_mid_data_clr",  read_data1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_val(32'h0); check("rst_rel_stall", {31'h0, stall_id});
        expect_val(32'h0); check("rst_rel_data",  read_data1);
        read_reg2 = 5'd5;
        #1;
        expect_val(32'h0); check("rst_rel_r5", read_data2);

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL leftover: observed %0d unchecked, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
